uart_loader: RTL and testbench

Boot loader that receives a program image over a UART RX line and writes it word-by-word into the shared 30-bit word-addressed RAM bus, holding the CPU in reset until the image is complete. While `cpu_hold` is high, the top level routes this block's bus outputs to the RAM. The CPU's bus drives the RAM only after release. It sits directly upstream of the RAM write port and the CPU reset input.

---
 rtl/uart_loader.sv | 179 +++++++++++++++++
 tb/tb_uart_loader.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_loader.sv
// Boot loader: 8N1 UART byte stream -> 32-bit word writes on the shared RAM bus, CPU held in reset until done.
// Write strobe 1 cycle after byte_valid of a word's last byte. The UART cannot be stalled, so there is no backpressure.
module uart_loader #(
    parameter int DIVISOR = 868
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        uart_rx,
    output logic [29:0] bus_addr,
    output logic [31:0] bus_data_w,
    output logic [3:0]  bus_mask_w,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);
    localparam int CW = (DIVISOR > 2) ? $clog2(DIVISOR) : 2;
    localparam logic [CW-1:0] C_HALF = CW'(DIVISOR / 2 - 1);
    localparam logic [CW-1:0] C_FULL = CW'(DIVISOR - 1);

    typedef enum logic [1:0] {RIdle, RStart, RData, RStop} rx_state_t;
    typedef enum logic [1:0] {SCount, SData, SDone, SError} ld_state_t;

    logic          r_rx_meta, r_rx_s;
    rx_state_t     r_rx_state;
    logic [CW-1:0] r_bit_cnt;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_shift;
    logic          r_byte_vld;
    logic [7:0]    r_byte_dat;

    ld_state_t     r_ld_state;
    logic [1:0]    r_byte_num;
    logic [23:0]   r_asm;
    logic [29:0]   r_count;
    logic [29:0]   r_index;
    logic          r_last;
    logic [29:0]   r_bus_addr;
    logic [31:0]   r_bus_data;
    logic [3:0]    r_bus_mask;
    logic          r_cpu_hold, r_done, r_error;

    logic          w_tick;
    logic          w_frame_err;
    logic          w_word_end;
    logic [31:0]   w_word;

    assign w_tick      = (r_bit_cnt == '0);
    assign w_frame_err = (r_rx_state == RStop) && w_tick && !r_rx_s;
    assign w_word      = {r_byte_dat, r_asm};
    assign w_word_end  = r_byte_vld && (r_byte_num == 2'd3);

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_rx_meta  <= 1'b1;
            r_rx_s     <= 1'b1;
            r_rx_state <= RIdle;
            r_bit_cnt  <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_byte_vld <= 1'b0;
            r_byte_dat <= '0;
        end else begin
            r_rx_meta  <= uart_rx;
            r_rx_s     <= r_rx_meta;
            r_byte_vld <= 1'b0;
            case (r_rx_state)
                RIdle: begin
                    if (!r_rx_s) begin
                        r_rx_state <= RStart;
                        r_bit_cnt  <= C_HALF;
                    end
                end
                RStart: begin
                    if (!w_tick) begin
                        r_bit_cnt <= r_bit_cnt - CW'(1);
                    end else if (r_rx_s) begin
                        r_rx_state <= RIdle;
                    end else begin
                        r_rx_state <= RData;
                        r_bit_cnt  <= C_FULL;
                        r_bit_idx  <= '0;
                    end
                end
                RData: begin
                    if (!w_tick) begin
                        r_bit_cnt <= r_bit_cnt - CW'(1);
                    end else begin
                        r_shift   <= {r_rx_s, r_shift[7:1]};
                        r_bit_cnt <= C_FULL;
                        r_bit_idx <= r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'd7) r_rx_state <= RStop;
                    end
                end
                RStop: begin
                    if (!w_tick) begin
                        r_bit_cnt <= r_bit_cnt - CW'(1);
                    end else begin
                        // Straight back to idle so a start bit right after the stop sample is caught.
                        r_rx_state <= RIdle;
                        if (r_rx_s) begin
                            r_byte_vld <= 1'b1;
                            r_byte_dat <= r_shift;
                        end
                    end
                end
                default: r_rx_state <= RIdle;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_ld_state <= SCount;
            r_byte_num <= '0;
            r_asm      <= '0;
            r_count    <= '0;
            r_index    <= '0;
            r_last     <= 1'b0;
            r_bus_addr <= '0;
            r_bus_data <= '0;
            r_bus_mask <= '0;
            r_cpu_hold <= 1'b1;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_bus_mask <= 4'b0000;
            if (w_frame_err && (r_ld_state != SDone)) begin
                r_ld_state <= SError;
                r_error    <= 1'b1;
            end else begin
                case (r_ld_state)
                    SCount: begin
                        if (r_byte_vld) begin
                            r_asm      <= {r_byte_dat, r_asm[23:8]};
                            r_byte_num <= r_byte_num + 2'd1;
                            if (w_word_end) begin
                                if (w_word[29:0] == 30'd0) begin
                                    r_ld_state <= SDone;
                                    r_cpu_hold <= 1'b0;
                                    r_done     <= 1'b1;
                                end else begin
                                    r_count    <= w_word[29:0];
                                    r_index    <= '0;
                                    r_ld_state <= SData;
                                end
                            end
                        end
                    end
                    SData: begin
                        // Release waits one cycle after the final strobe so the RAM commits it first.
                        if (r_last) begin
                            r_ld_state <= SDone;
                            r_cpu_hold <= 1'b0;
                            r_done     <= 1'b1;
                        end else if (r_byte_vld) begin
                            r_asm      <= {r_byte_dat, r_asm[23:8]};
                            r_byte_num <= r_byte_num + 2'd1;
                            if (w_word_end) begin
                                r_bus_addr <= r_index;
                                r_bus_data <= w_word;
                                r_bus_mask <= 4'b1111;
                                r_index    <= r_index + 30'd1;
                                r_last     <= ((r_index + 30'd1) == r_count);
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus_addr   = r_bus_addr;
    assign bus_data_w = r_bus_data;
    assign bus_mask_w = r_bus_mask;
    assign cpu_hold   = r_cpu_hold;
    assign done       = r_done;
    assign error      = r_error;
endmodule

// File: tb/tb_uart_loader.sv
// Directed bench for uart_loader with DIVISOR = 4: table of byte streams plus glitch and mid-word reset sequences.
module tb_uart_loader;
    localparam int D = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        uart_rx;
    logic [29:0] bus_addr;
    logic [31:0] bus_data_w;
    logic [3:0]  bus_mask_w;
    logic        cpu_hold, done, error;

    uart_loader #(.DIVISOR(D)) dut (
        .clock(clock), .reset(reset), .uart_rx(uart_rx),
        .bus_addr(bus_addr), .bus_data_w(bus_data_w), .bus_mask_w(bus_mask_w),
        .cpu_hold(cpu_hold), .done(done), .error(error)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Strobe and release monitor, sampled on the falling edge.
    logic [29:0] s_addr[$];
    logic [31:0] s_data[$];
    int          s_cyc[$];
    int          done_rise[$];
    int          n_partial = 0;
    bit          prev_done = 1'b0;
    always @(negedge clock) begin
        if (bus_mask_w != 4'b0000) begin
            s_addr.push_back(bus_addr);
            s_data.push_back(bus_data_w);
            s_cyc.push_back(cyc);
            if (bus_mask_w != 4'b1111) n_partial = n_partial + 1;
        end
        if (done === 1'b1 && !prev_done) done_rise.push_back(cyc);
        prev_done = (done === 1'b1);
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_stop, output int start);
        start = cyc;
        uart_rx = 1'b0;
        repeat (D) tick();
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (D) tick();
        end
        uart_rx = bad_stop ? 1'b0 : 1'b1;
        repeat (D) tick();
        uart_rx = 1'b1;
        if (bad_stop) repeat (D) tick();
    endtask

    task automatic reset_and_check(input string tag);
        reset = 1'b0;
        uart_rx = 1'b1;
        repeat (3) tick();
        chk({tag, "_rst_hold"}, cpu_hold, 1'b1);
        chk({tag, "_rst_done"}, done, 1'b0);
        chk({tag, "_rst_err"}, error, 1'b0);
        chk({tag, "_rst_mask"}, bus_mask_w, 4'b0000);
        chk({tag, "_rst_addr"}, bus_addr, 30'd0);
        chk({tag, "_rst_data"}, bus_data_w, 32'd0);
        reset = 1'b1;
        tick();
    endtask

    typedef struct {
        string        name;
        int           n;
        logic [127:0] bytes;   // byte i at [8*i +: 8]
        int           bad;     // index of byte sent with stop bit 0, -1 for none
        int           ns;
        logic [29:0]  a0, a1;
        logic [31:0]  d0, d1;
        logic         dn, er;
    } vec_t;

    vec_t tv[5];
    int   starts[16];
    int   lat_ref = 42;

    initial begin
        int base_s, base_d, base_p, st, ns_got, last;

        tv[0] = '{"two_word", 13, 128'h55_00000013_DEADBEEF_00000002, -1, 2,
                  30'd0, 30'd1, 32'hDEADBEEF, 32'h00000013, 1'b1, 1'b0};
        tv[1] = '{"empty", 4, 128'h00000000, -1, 0, 30'd0, 30'd0, 32'd0, 32'd0, 1'b1, 1'b0};
        tv[2] = '{"frame_err", 15, 128'h887766_55443322_11CCBBAA_00000002, 6, 0,
                  30'd0, 30'd0, 32'd0, 32'd0, 1'b0, 1'b1};
        tv[3] = '{"count_hi_bits", 8, 128'h12345678_C0000001, -1, 1,
                  30'd0, 30'd0, 32'h12345678, 32'd0, 1'b1, 1'b0};
        tv[4] = '{"err_after_done", 6, 128'h99_3C_00000000, 4, 0,
                  30'd0, 30'd0, 32'd0, 32'd0, 1'b1, 1'b0};

        reset = 1'b0;
        uart_rx = 1'b1;

        for (int v = 0; v < 5; v++) begin
            reset_and_check(tv[v].name);
            base_s = s_addr.size();
            base_d = done_rise.size();
            base_p = n_partial;
            for (int i = 0; i < tv[v].n; i++) begin
                send_byte(tv[v].bytes[8*i +: 8], (i == tv[v].bad), st);
                starts[i] = st;
            end
            repeat (60) tick();

            ns_got = s_addr.size() - base_s;
            chk({tv[v].name, "_strobes"}, ns_got, tv[v].ns);
            for (int j = 0; j < tv[v].ns; j++) begin
                if (j < ns_got) begin
                    chk({tv[v].name, "_addr"}, s_addr[base_s + j], (j == 0) ? tv[v].a0 : tv[v].a1);
                    chk({tv[v].name, "_data"}, s_data[base_s + j], (j == 0) ? tv[v].d0 : tv[v].d1);
                end
            end
            chk({tv[v].name, "_done"}, done, tv[v].dn);
            chk({tv[v].name, "_error"}, error, tv[v].er);
            chk({tv[v].name, "_hold"}, cpu_hold, !tv[v].dn);
            chk({tv[v].name, "_partial"}, n_partial - base_p, 0);
            if (tv[v].ns > 0 && ns_got == tv[v].ns) begin
                last = base_s + ns_got - 1;
                chk({tv[v].name, "_addr_held"}, bus_addr, s_addr[last]);
                chk({tv[v].name, "_data_held"}, bus_data_w, s_data[last]);
                if (v == 0) begin
                    // Strobe is T+1 after the last byte; expected ~9.5 bit times plus sync/detect.
                    lat_ref = s_cyc[last] - starts[tv[v].n - 2];
                    chk("write_latency_range", (lat_ref >= 40 && lat_ref <= 44), 1'b1);
                end
                if (done_rise.size() > base_d)
                    chk({tv[v].name, "_release_gap"}, done_rise[base_d] - s_cyc[last], 1);
            end
            if (tv[v].dn && tv[v].ns == 0 && done_rise.size() > base_d)
                chk({tv[v].name, "_release_lat"}, done_rise[base_d] - starts[3], lat_ref);
        end

        // One-cycle low glitch in idle must not be taken as a byte.
        reset_and_check("glitch");
        base_s = s_addr.size();
        uart_rx = 1'b0;
        tick();
        uart_rx = 1'b1;
        repeat (20) tick();
        chk("glitch_no_strobe", s_addr.size() - base_s, 0);
        chk("glitch_done", done, 1'b0);
        chk("glitch_error", error, 1'b0);
        begin
            logic [7:0] gb[8] = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hA5, 8'h5A, 8'h0F, 8'hF0};
            for (int i = 0; i < 8; i++) send_byte(gb[i], 1'b0, st);
        end
        repeat (60) tick();
        chk("glitch_strobes", s_addr.size() - base_s, 1);
        if (s_addr.size() > base_s) begin
            chk("glitch_addr", s_addr[base_s], 30'd0);
            chk("glitch_data", s_data[base_s], 32'hF00F5AA5);
        end
        chk("glitch_done_end", done, 1'b1);

        // Reset pulse mid-word discards partial byte, word and index.
        reset_and_check("midrst");
        base_s = s_addr.size();
        begin
            logic [7:0] pb[6] = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22};
            for (int i = 0; i < 6; i++) send_byte(pb[i], 1'b0, st);
        end
        reset = 1'b0;
        tick();
        chk("midrst_hold", cpu_hold, 1'b1);
        chk("midrst_done", done, 1'b0);
        chk("midrst_mask", bus_mask_w, 4'b0000);
        reset = 1'b1;
        tick();
        begin
            logic [7:0] rb[8] = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
            for (int i = 0; i < 8; i++) send_byte(rb[i], 1'b0, st);
        end
        repeat (60) tick();
        chk("midrst_strobes", s_addr.size() - base_s, 1);
        if (s_addr.size() > base_s) begin
            chk("midrst_addr", s_addr[base_s], 30'd0);
            chk("midrst_data", s_data[base_s], 32'h12345678);
        end
        chk("midrst_done_end", done, 1'b1);
        chk("midrst_hold_end", cpu_hold, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
